// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants and FSM encoding for the IF-stage fetch unit
package if_fetch_unit_pkg;
  localparam logic [29:0] RESET_PC_DEF     = 30'h00000C00;
  localparam logic [29:0] EXC_HANDLER_ADDR = 30'h00001060;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_skid.sv
// if_fetch_unit_skid: one-entry skid register holding a fetched instruction while ID stalls
// Ports: clk/rst (async active-high), load_i captures pc_i/instr_i, unload_i empties,
// flush_i empties with priority over load; valid_o/pc_o/instr_o show the held entry.
module if_fetch_unit_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        flush_i,
  input  logic [29:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [29:0] pc_o,
  output logic [31:0] instr_o
);
  logic        valid_q, valid_d;
  logic [29:0] pc_q;
  logic [31:0] instr_q;
  always_comb valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : unload_i ? 1'b0 : valid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i && !flush_i) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end
    end
  end
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage fetch engine owning the fetch PC, imem request and the ID handoff
// Ports: clk/rst (async active-high); redirect_i/redirect_pc_i control transfer from ID;
// stall_i holds if_* outputs; imem_req_o/imem_addr_o/imem_rvalid_i/imem_rdata_i is the
// single-outstanding instruction memory port; if_valid_o/if_pc_o/if_instr_o feed ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [29:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [29:0] if_pc_o,
  output logic [31:0] if_instr_o
);
  fetch_state_e state_q, state_d;
  logic [29:0]  pc_q, pc_d, fetch_addr_q, fetch_addr_d, pc_inc;
  logic         if_valid_q, if_valid_d;
  logic [29:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         out_free, skid_load, skid_unload, skid_flush, skid_valid;
  logic [29:0]  skid_pc;
  logic [31:0]  skid_instr;
  if_fetch_unit_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .pc_i     (fetch_addr_q),
    .instr_i  (imem_rdata_i),
    .valid_o  (skid_valid),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );
  assign pc_inc   = pc_q + 30'd1;
  assign out_free = !if_valid_q || !stall_i;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    if_valid_d   = if_valid_q && stall_i;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;
    if (redirect_i) begin
      if_valid_d = 1'b0;
      skid_flush = 1'b0 | 1'b1;
      pc_d       = redirect_pc_i;
      // An in-flight request cannot be abandoned: wait in DRAIN for its response.
      if ((state_q == FETCH || state_q == DRAIN) && !imem_rvalid_i) begin
        state_d = DRAIN;
      end else begin
        state_d      = FETCH;
        fetch_addr_d = redirect_pc_i;
      end
    end else if (state_q == IDLE) begin
      state_d      = FETCH;
      fetch_addr_d = pc_q;
    end else if (state_q == FETCH && imem_rvalid_i) begin
      pc_d = pc_inc;
      if (out_free) begin
        if_valid_d   = 1'b1;
        if_pc_d      = fetch_addr_q;
        if_instr_d   = imem_rdata_i;
        fetch_addr_d = pc_inc;
      end else begin
        skid_load = 1'b1;
        state_d   = HOLD;
      end
    end else if (state_q == HOLD && !stall_i) begin
      if_valid_d   = skid_valid;
      if_pc_d      = skid_pc;
      if_instr_d   = skid_instr;
      skid_unload  = 1'b1;
      fetch_addr_d = pc_q;
      state_d      = FETCH;
    end else if (state_q == DRAIN && imem_rvalid_i) begin
      fetch_addr_d = pc_q;
      state_d      = FETCH;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end
  assign imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr_o = fetch_addr_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed table, corner sequences and randomized scoreboard for if_fetch_unit
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;
  logic        clk = 1'b0;
  logic        rst, redirect, stall, rvalid;
  logic [29:0] redirect_pc;
  logic [31:0] rdata;
  logic        imem_req, if_valid;
  logic [29:0] imem_addr, if_pc;
  logic [31:0] if_instr;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .if_valid_o    (if_valid),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr)
  );
  function automatic logic [31:0] h(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hA5A5_0000;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {
    logic        stall, rv, redir;
    logic [29:0] rpc;
    logic        req;
    logic [29:0] addr;
    logic        valid;
    logic [29:0] pc;
  } vec_t;
  function automatic vec_t mk(input logic s, input logic v, input logic r, input logic [29:0] rp,
                              input logic q, input logic [29:0] a, input logic iv, input logic [29:0] p);
    vec_t t;
    t.stall = s; t.rv = v; t.redir = r; t.rpc = rp;
    t.req = q; t.addr = a; t.valid = iv; t.pc = p;
    return t;
  endfunction
  vec_t tv[17];
  initial begin
    logic [29:0] exp_pc, prev_addr;
    logic        prev_redir, req_pending;
    int          wait_n, lat, delivered;
    // Each row: inputs applied this cycle, outputs expected at the start of the cycle.
    tv[0]  = mk(0, 0, 0, 0,                0, 30'hC00,  0, 0);
    tv[1]  = mk(0, 1, 0, 0,                1, 30'hC00,  0, 0);
    tv[2]  = mk(0, 1, 0, 0,                1, 30'hC01,  1, 30'hC00);
    tv[3]  = mk(1, 1, 0, 0,                1, 30'hC02,  1, 30'hC01);
    tv[4]  = mk(1, 0, 0, 0,                0, 30'hC02,  1, 30'hC01);
    tv[5]  = mk(1, 0, 0, 0,                0, 30'hC02,  1, 30'hC01);
    tv[6]  = mk(0, 0, 0, 0,                0, 30'hC02,  1, 30'hC01);
    tv[7]  = mk(0, 1, 0, 0,                1, 30'hC03,  1, 30'hC02);
    tv[8]  = mk(0, 0, 0, 0,                1, 30'hC04,  1, 30'hC03);
    tv[9]  = mk(0, 1, 0, 0,                1, 30'hC04,  0, 0);
    tv[10] = mk(0, 0, 1, EXC_HANDLER_ADDR, 1, 30'hC05,  1, 30'hC04);
    tv[11] = mk(0, 0, 0, 0,                1, 30'hC05,  0, 0);
    tv[12] = mk(0, 1, 0, 0,                1, 30'hC05,  0, 0);
    tv[13] = mk(0, 1, 0, 0,                1, 30'h1060, 0, 0);
    tv[14] = mk(1, 1, 1, 30'h2000,         1, 30'h1061, 1, 30'h1060);
    tv[15] = mk(0, 1, 0, 0,                1, 30'h2000, 0, 0);
    tv[16] = mk(0, 0, 0, 0,                1, 30'h2001, 1, 30'h2000);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_addr", {2'b0, imem_addr}, {2'b0, 30'hC00});
    chk("rst_valid", {31'd0, if_valid}, 0);
    chk("rst_pc", {2'b0, if_pc}, 0);
    chk("rst_instr", if_instr, 0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tv[i].req});
      chk($sformatf("v%0d_addr", i), {2'b0, imem_addr}, {2'b0, tv[i].addr});
      chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, tv[i].valid});
      if (tv[i].valid) begin
        chk($sformatf("v%0d_pc", i), {2'b0, if_pc}, {2'b0, tv[i].pc});
        chk($sformatf("v%0d_instr", i), if_instr, h(tv[i].pc));
      end
      stall = tv[i].stall; rvalid = tv[i].rv; redirect = tv[i].redir;
      redirect_pc = tv[i].rpc; rdata = h(imem_addr);
      @(negedge clk);
    end
    // Address wrap: redirect to the top word, then fetch past it.
    rvalid = 1'b1; redirect = 1'b1; redirect_pc = 30'h3FFFFFFF; rdata = h(imem_addr);
    @(negedge clk);
    chk("wrap_addr0", {2'b0, imem_addr}, {2'b0, 30'h3FFFFFFF});
    chk("wrap_valid0", {31'd0, if_valid}, 0);
    redirect = 1'b0; rdata = h(imem_addr);
    @(negedge clk);
    chk("wrap_pc", {2'b0, if_pc}, {2'b0, 30'h3FFFFFFF});
    chk("wrap_instr", if_instr, h(30'h3FFFFFFF));
    chk("wrap_addr1", {2'b0, imem_addr}, 0);
    // Enter DRAIN, then reset asynchronously in the middle of the cycle.
    rvalid = 1'b0; redirect = 1'b1; redirect_pc = EXC_HANDLER_ADDR;
    @(negedge clk);
    chk("drain_req", {31'd0, imem_req}, 1);
    chk("drain_addr", {2'b0, imem_addr}, 0);
    chk("drain_valid", {31'd0, if_valid}, 0);
    redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 0);
    chk("arst_addr", {2'b0, imem_addr}, {2'b0, 30'hC00});
    chk("arst_valid", {31'd0, if_valid}, 0);
    chk("arst_pc", {2'b0, if_pc}, 0);
    chk("arst_instr", if_instr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_req", {31'd0, imem_req}, 1);
    chk("restart_addr", {2'b0, imem_addr}, {2'b0, 30'hC00});
    // Randomized phase: program-order scoreboard plus request-protocol checks.
    exp_pc = 30'hC00; prev_addr = '0; prev_redir = 1'b0; req_pending = 1'b0;
    wait_n = 0; lat = $urandom_range(1, 3); delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (req_pending) begin
        chk("rand_req_held", {31'd0, imem_req}, 1);
        chk("rand_addr_stable", {2'b0, imem_addr}, {2'b0, prev_addr});
      end
      if (prev_redir) chk("rand_squash", {31'd0, if_valid}, 0);
      stall = ($urandom % 4) == 0;
      redirect = ($urandom % 20) == 0;
      case ($urandom % 3)
        0: redirect_pc = EXC_HANDLER_ADDR;
        1: redirect_pc = 30'h3FFFFFFF;
        default: redirect_pc = 30'($urandom);
      endcase
      rvalid = imem_req && (wait_n >= lat - 1);
      rdata = h(imem_addr);
      if (if_valid && !stall && !redirect) begin
        chk("rand_pc", {2'b0, if_pc}, {2'b0, exp_pc});
        chk("rand_instr", if_instr, h(exp_pc));
        exp_pc = if_pc + 30'd1;
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_redir = redirect;
      req_pending = imem_req && !rvalid;
      prev_addr = imem_addr;
      if (rvalid) begin
        wait_n = 0;
        lat = $urandom_range(1, 3);
      end else if (imem_req) wait_n++;
      @(negedge clk);
    end
    chk("rand_progress", {31'd0, delivered >= 300}, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
